// File: rtl/regfile_mux_nr1w.sv
// regfile_mux_nr1w: 2**ADDR_W x DATA_W register file, one synchronous write port and
// NUM_RD independent combinational read ports. Define REGFILE_BYPASS_EN for write-through forwarding.
module regfile_mux_nr1w #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0] o_rd_data,
    input  logic                     i_wr_en,
    input  logic [ADDR_W-1:0]        i_wr_addr,
    input  logic [DATA_W-1:0]        i_wr_data,
    output logic [15:0]              o_wr_count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [15:0]       r_wr_count;
    logic              w_wr_zero;
    logic              w_commit;

    // A write aimed at the hardwired zero entry is discarded and never counted.
    assign w_wr_zero = (ZERO_REG != 0) && (i_wr_addr == '0);
    assign w_commit  = i_wr_en && !w_wr_zero;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_count <= '0;
        end else begin
            if (w_commit) begin
                r_mem[i_wr_addr] <= i_wr_data;
            end
            if (w_commit && (r_wr_count != 16'hFFFF)) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
        end
    end

    assign o_wr_count = r_wr_count;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] w_addr;
            logic [DATA_W-1:0] w_stored;
            logic [DATA_W-1:0] w_data;
            logic              w_zero;

            assign w_addr   = i_rd_addr[gi*ADDR_W +: ADDR_W];
            assign w_stored = r_mem[w_addr];
            assign w_zero   = (ZERO_REG != 0) && (w_addr == '0);
`ifdef REGFILE_BYPASS_EN
            logic w_fwd;
            // Forward the in-flight write so the reader sees it before the edge.
            assign w_fwd  = i_wr_en && !i_reset && (w_addr == i_wr_addr);
            assign w_data = w_zero ? '0 : (w_fwd ? i_wr_data : w_stored);
`else
            assign w_data = w_zero ? '0 : w_stored;
`endif
            assign o_rd_data[gi*DATA_W +: DATA_W] = w_data;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mux_nr1w.sv
// Self-checking bench for regfile_mux_nr1w: table-driven vectors plus hand sequences,
// with expected read data / write count carried through a scoreboard queue.
module tb_regfile_mux_nr1w;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;

    logic                     clk;
    logic                     i_reset;
    logic [NUM_RD*ADDR_W-1:0] i_rd_addr;
    logic [NUM_RD*DATA_W-1:0] o_rd_data;
    logic                     i_wr_en;
    logic [ADDR_W-1:0]        i_wr_addr;
    logic [DATA_W-1:0]        i_wr_data;
    logic [15:0]              o_wr_count;

    regfile_mux_nr1w #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_RD  (NUM_RD),
        .ZERO_REG(1)
    ) dut (
        .i_clk     (clk),
        .i_reset   (i_reset),
        .i_rd_addr (i_rd_addr),
        .o_rd_data (o_rd_data),
        .i_wr_en   (i_wr_en),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .o_wr_count(o_wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [15:0] ecnt;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [15:0] ecnt;
    } exp_t;

    vec_t vecs [12];
    exp_t sb_q [$];
    int   checks = 0;
    int   errors = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, queue the expected pre-edge outputs, compare at negedge, then clock.
    task automatic step(input vec_t v);
        exp_t e;
        i_reset   = v.rst;
        i_wr_en   = v.we;
        i_wr_addr = v.wa;
        i_wr_data = v.wd;
        i_rd_addr = {v.ra1, v.ra0};
        sb_q.push_back('{v.name, v.e0, v.e1, v.ecnt});
        @(negedge clk);
        e = sb_q.pop_front();
        cmp({e.name, "_rd0"}, o_rd_data[31:0], e.e0);
        cmp({e.name, "_rd1"}, o_rd_data[63:32], e.e1);
        cmp({e.name, "_cnt"}, {16'h0, o_wr_count}, {16'h0, e.ecnt});
        $display("%-12s rst=%0b we=%0b wa=%0d wd=%h ra=%0d/%0d rd=%h/%h cnt=%h",
                 v.name, v.rst, v.we, v.wa, v.wd, v.ra0, v.ra1,
                 o_rd_data[31:0], o_rd_data[63:32], o_wr_count);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] conflict_exp;

    initial begin
        //            name          rst  we  wa  wd            ra0 ra1 e0            e1            cnt
        vecs[0]  = '{"wr_x5",      0, 1, 5,  32'hDEADBEEF, 7,  0,  32'h0,        32'h0,        16'd0};
        vecs[1]  = '{"rd_x5",      0, 0, 0,  32'h0,        5,  7,  32'hDEADBEEF, 32'h0,        16'd1};
        vecs[2]  = '{"reset",      1, 0, 0,  32'h0,        5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 16'd1};
        vecs[3]  = '{"wr_x7",      0, 1, 7,  32'h12345678, 5,  31, 32'h0,        32'h0,        16'd0};
        vecs[4]  = '{"wr_x31",     0, 1, 31, 32'hCAFEF00D, 7,  5,  32'h12345678, 32'h0,        16'd1};
        vecs[5]  = '{"wr_x0",      0, 1, 0,  32'hFFFFFFFF, 7,  31, 32'h12345678, 32'hCAFEF00D, 16'd2};
        vecs[6]  = '{"rd_x0",      0, 0, 0,  32'h0,        0,  0,  32'h0,        32'h0,        16'd2};
        vecs[7]  = '{"wr_x9",      0, 1, 9,  32'h11,       31, 7,  32'hCAFEF00D, 32'h12345678, 16'd2};
        vecs[8]  = '{"rst_mid_wr", 1, 1, 3,  32'hAA,       9,  3,  32'h11,       32'h0,        16'd3};
        vecs[9]  = '{"post_rst",   0, 0, 0,  32'h0,        3,  9,  32'h0,        32'h0,        16'd0};
        vecs[10] = '{"wr_x3",      0, 1, 3,  32'h55,       1,  2,  32'h0,        32'h0,        16'd0};
        vecs[11] = '{"rd_x3",      0, 0, 0,  32'h0,        3,  3,  32'h55,       32'h55,       16'd1};

        i_reset   = 1'b1;
        i_wr_en   = 1'b0;
        i_wr_addr = '0;
        i_wr_data = '0;
        i_rd_addr = '0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            step(vecs[i]);
        end

        // Same-cycle read/write of x9: old value unless forwarding is built in.
`ifdef REGFILE_BYPASS_EN
        conflict_exp = 32'h22;
`else
        conflict_exp = 32'h11;
`endif
        step('{"set_x9",    0, 1, 9, 32'h11,  0, 2, 32'h0, 32'h0,        16'd1});
        step('{"rd_x9",     0, 0, 0, 32'h0,   0, 9, 32'h0, 32'h11,       16'd2});
        step('{"conflict",  0, 1, 9, 32'h22,  0, 9, 32'h0, conflict_exp, 16'd2});
        step('{"after_edge",0, 0, 0, 32'h0,   0, 9, 32'h0, 32'h22,       16'd3});
        step('{"wr0_rd0",   0, 1, 0, 32'h77,  0, 0, 32'h0, 32'h0,        16'd3});
        step('{"rd0_again", 0, 0, 0, 32'h0,   0, 0, 32'h0, 32'h0,        16'd3});

        // Counter saturation: 65540 writes to x1 starting from count 3, data = write index.
        i_rd_addr = {5'd0, 5'd2};
        for (int n = 0; n < 65540; n++) begin
            i_reset   = 1'b0;
            i_wr_en   = 1'b1;
            i_wr_addr = 5'd1;
            i_wr_data = n;
            @(posedge clk);
            #1;
            if (n == 65530) begin
                i_wr_en = 1'b0;
                cmp("cnt_ffe", {16'h0, o_wr_count}, 32'h0000FFFE);
                $display("burst        writes=%0d cnt=%h", n + 1, o_wr_count);
            end
            if (n == 65531) begin
                i_wr_en = 1'b0;
                cmp("cnt_fff", {16'h0, o_wr_count}, 32'h0000FFFF);
                $display("burst        writes=%0d cnt=%h", n + 1, o_wr_count);
            end
        end
        step('{"saturated", 0, 0, 0, 32'h0, 1, 0, 32'h00010003, 32'h0, 16'hFFFF});

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got %0d expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mux_nr1w.md
Name: regfile_mux_nr1w

Overview:
- Parametrised register file: 2^ADDR_W entries of DATA_W bits, one synchronous write port, NUM_RD independent asynchronous read ports.
- Each read port is a generalised select-mux over the storage array.
- Replaces the fixed 32x32 single-port read mux in the decode stage; serves rs1/rs2 (NUM_RD=2), or more ports for future dual-issue.
- Optional same-cycle write-to-read forwarding.

Parameters:
- DATA_W, 32, width of each register and each data port.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1: entry 0 hardwired to zero; 0: entry 0 is an ordinary register.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_rd_addr  input  NUM_RD*ADDR_W  flattened read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- o_rd_data  output  NUM_RD*DATA_W  flattened read data; port k uses bits [k*DATA_W +: DATA_W].
- i_wr_en  input  1  write enable.
- i_wr_addr  input  ADDR_W  write address.
- i_wr_data  input  DATA_W  write data.
- o_wr_count  output  16  saturating count of committed writes; debug/perf.

Behaviour:
- Reset is decided: one clock i_clk; reset i_reset is synchronous, active-high.
  - On a rising i_clk edge with i_reset=1, all 2**ADDR_W entries clear to 0 and o_wr_count clears to 0.
  - i_wr_en is ignored in that cycle.
- Reset mid-operation:
  - A write presented in the reset cycle is dropped.
  - The first write after reset deasserts is accepted in the next cycle.
- Write:
  - On a rising edge with i_reset=0 and i_wr_en=1, mem[i_wr_addr] <= i_wr_data.
  - Write latency 1 cycle; the new value is visible on read ports after that edge.
- Write to entry 0 when ZERO_REG=1:
  - Storage is not modified.
  - o_wr_count is not incremented; such a write is not "committed".
- Read:
  - Combinational, zero latency: o_rd_data[k] = mem[i_rd_addr[k]].
  - When ZERO_REG=1 and i_rd_addr[k]==0, port k reads 0 regardless of storage.
- All read ports are fully independent; any number may address the same entry simultaneously.
- Out-of-range addresses cannot occur (full decode); no default/X path.
  - Outputs never carry X after the first reset.
- o_wr_count:
  - Increments by 1 on each committed write.
  - Saturates at 16'hFFFF; it does not wrap.
- Outputs at reset:
  - o_rd_data = 0 on all ports (storage is zero).
  - o_wr_count = 0.
- Simultaneous read and write of the same address, same cycle, without bypass: read returns the old value until the edge.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - When i_wr_en=1, i_reset=0 and i_rd_addr[k]==i_wr_addr, port k returns i_wr_data in the same cycle (write-through forwarding).
  - Forwarding never applies to entry 0 when ZERO_REG=1; that read stays 0.
  - With i_reset=1, no forwarding occurs.
- Not defined:
  - No forwarding logic is generated.
  - Reads always reflect stored state only, as described in Behaviour.

Test Plan:
- Reset:
  - Write 0xDEADBEEF to x5, then assert i_reset 1 cycle, read x5 on port 0.
  - Required: 0x00000000; o_wr_count=0.
- Basic write/read:
  - Write x7=0x12345678, x31=0xCAFEF00D; port0 reads x7, port1 reads x31.
  - Required: 0x12345678 and 0xCAFEF00D; o_wr_count=2.
- Zero register (ZERO_REG=1):
  - Write x0=0xFFFFFFFF, then read x0 on both ports.
  - Required: both 0; o_wr_count unchanged.
- Same-cycle read/write conflict:
  - x9 holds 0x11; present write x9=0x22 and read x9 on port1 in the same cycle.
  - Without REGFILE_BYPASS_EN: 0x11 before the edge, 0x22 after.
  - With REGFILE_BYPASS_EN: 0x22 immediately.
- Reset mid-write:
  - Assert i_wr_en, x3=0xAA together with i_reset=1.
  - Required: after the edge x3 reads 0; o_wr_count=0.
- Counter saturation:
  - Force 65540 writes to x1.
  - Required: o_wr_count holds 0xFFFF; x1 equals the last data written.
